sig_input_conditioner: RTL



---
 rtl/sig_input_conditioner_if.sv | 24 ++
 rtl/sig_input_conditioner.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sig_input_conditioner_if.sv
// Bundle of the raw-input, qualified-output and glitch-counter signals of sig_input_conditioner.
// master = upstream driver / observer, slave = the conditioner itself.
interface sig_input_conditioner_if #(
   parameter int CNT_W    = 4,
   parameter int GLITCH_W = 8
);
   logic                raw_in;
   logic [CNT_W-1:0]    stable_cnt;
   logic                glitch_clr;
   logic                sig_out;
   logic                rise_pulse;
   logic                fall_pulse;
   logic [GLITCH_W-1:0] glitch_cnt;

   modport master (
      output raw_in, stable_cnt, glitch_clr,
      input  sig_out, rise_pulse, fall_pulse, glitch_cnt
   );

   modport slave (
      input  raw_in, stable_cnt, glitch_clr,
      output sig_out, rise_pulse, fall_pulse, glitch_cnt
   );
endinterface

// File: rtl/sig_input_conditioner.sv
// Synchronises raw_in, qualifies each level change over N stable samples and emits rise/fall strobes.
// Optional glitch counter enabled by defining SIG_INPUT_CONDITIONER_GLITCH_CNT_EN.
module sig_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int GLITCH_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sig_input_conditioner_if.slave bus
);
   localparam logic [1:0] ST_LOW    = 2'd0;
   localparam logic [1:0] ST_QUAL_H = 2'd1;
   localparam logic [1:0] ST_HIGH   = 2'd2;
   localparam logic [1:0] ST_QUAL_L = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   syn;
   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       n_q, n_d;
   logic [CNT_W-1:0]       n_eff;
   logic                   sig_out_q, sig_out_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   glitch_evt;

   assign syn   = sync_q[SYNC_STAGES-1];
   assign n_eff = (bus.stable_cnt == '0) ? CNT_W'(1) : bus.stable_cnt;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.raw_in};
   end

   // N is captured on entry to a qualifying state so mid-run stable_cnt changes apply next time.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      glitch_evt = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (syn) begin
               if (n_eff == CNT_W'(1)) begin
                  state_d = ST_HIGH;
                  rise_d  = 1'b1;
               end else begin
                  state_d = ST_QUAL_H;
                  cnt_d   = CNT_W'(1);
                  n_d     = n_eff;
               end
            end
         end
         ST_QUAL_H: begin
            if (!syn) begin
               state_d    = ST_LOW;
               cnt_d      = '0;
               glitch_evt = 1'b1;
            end else if (cnt_q + CNT_W'(1) == n_q) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (!syn) begin
               if (n_eff == CNT_W'(1)) begin
                  state_d = ST_LOW;
                  fall_d  = 1'b1;
               end else begin
                  state_d = ST_QUAL_L;
                  cnt_d   = CNT_W'(1);
                  n_d     = n_eff;
               end
            end
         end
         default: begin
            if (syn) begin
               state_d    = ST_HIGH;
               cnt_d      = '0;
               glitch_evt = 1'b1;
            end else if (cnt_q + CNT_W'(1) == n_q) begin
               state_d = ST_LOW;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
      sig_out_d = (state_d == ST_HIGH) || (state_d == ST_QUAL_L);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         state_q   <= ST_LOW;
         cnt_q     <= '0;
         n_q       <= '0;
         sig_out_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         n_q       <= n_d;
         sig_out_q <= sig_out_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign bus.sig_out    = sig_out_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;

`ifdef SIG_INPUT_CONDITIONER_GLITCH_CNT_EN
   logic [GLITCH_W-1:0] glitch_q, glitch_d;

   // Clear takes priority over a coincident glitch event; the count saturates at all-ones.
   always_comb begin
      glitch_d = glitch_q;
      if (bus.glitch_clr) begin
         glitch_d = '0;
      end else if (glitch_evt && (glitch_q != '1)) begin
         glitch_d = glitch_q + GLITCH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign bus.glitch_cnt = glitch_q;
`else
   logic glitch_unused;
   assign glitch_unused  = glitch_evt ^ bus.glitch_clr;
   assign bus.glitch_cnt = '0;
`endif
endmodule
